prog_timer: RTL and testbench

//   Parametrised down-counting timer with internal prescaler. Successor to the

---
 rtl/prog_timer.sv | 125 ++++++++++++
 tb/tb_prog_timer.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_timer.sv
// Programmable down-counting timer with an internal prescaler.
// A start loads a count and runs; each prescaler wrap produces one tick and
// decrements the count. The last tick either ends the run (one-shot) or
// reloads the loaded count (auto-reload). Pause freezes the run and cancel
// aborts it without an expiry. Every output comes straight from a flop.
module prog_timer #(
   parameter int unsigned CLK_HZ  = 100_000_000,
   parameter int unsigned TICK_HZ = 1,
   parameter int unsigned CNT_W   = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [CNT_W-1:0] value,
   input  logic             start_timer,
   input  logic             pause,
   input  logic             cancel,
   input  logic             auto_reload,
   output logic             expired,
   output logic             expired_pulse,
   output logic             one_hz_enable,
   output logic             running,
   output logic [CNT_W-1:0] remaining
);

   localparam int unsigned Prescale = CLK_HZ / TICK_HZ;
   localparam int unsigned PsWidth  = (Prescale > 1) ? $clog2(Prescale) : 1;
   localparam logic [PsWidth-1:0] PsLast = PsWidth'(Prescale - 1);
   localparam logic [CNT_W-1:0]   CntOne = CNT_W'(1);

   if (Prescale < 1) begin : gen_bad_prescale
      $error("prog_timer: CLK_HZ / TICK_HZ must be at least 1");
   end

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StHold
   } state_e;

   state_e             state_q;
   logic [PsWidth-1:0] prescaler_q;
   logic [CNT_W-1:0]   reload_q;

   logic active;
   logic wrap;
   logic last_tick;

   // Decode of the current run status used by the sequential block.
   always_comb begin
      active    = (state_q != StIdle);
      wrap      = (prescaler_q == PsLast);
      // <= 1 rather than == 1 so a stray zero count can never wrap around.
      last_tick = (remaining <= CntOne);
   end

   // Timer FSM: state, prescaler, reload value and all outputs update together.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= StIdle;
         prescaler_q   <= '0;
         reload_q      <= '0;
         expired       <= 1'b0;
         expired_pulse <= 1'b0;
         one_hz_enable <= 1'b0;
         running       <= 1'b0;
         remaining     <= '0;
      end else begin
         expired_pulse <= 1'b0;
         one_hz_enable <= 1'b0;

         if (start_timer) begin
            // Start wins in every state, so this is also the restart path.
            remaining   <= value;
            reload_q    <= value;
            prescaler_q <= '0;
            if (value == '0) begin
               // Zero count expires immediately without ever ticking.
               expired       <= 1'b1;
               expired_pulse <= 1'b1;
               running       <= 1'b0;
               state_q       <= StIdle;
            end else begin
               expired <= 1'b0;
               running <= 1'b1;
               state_q <= StRun;
            end
         end else if (cancel && active) begin
            // Abort: no pulse, and the expired level is left as it was.
            remaining   <= '0;
            prescaler_q <= '0;
            running     <= 1'b0;
            state_q     <= StIdle;
         end else if (pause && active) begin
            // Prescaler and count hold their values while paused.
            running <= 1'b0;
            state_q <= StHold;
         end else if (active) begin
            // Leaving HOLD counts on this same edge, so each paused cycle
            // costs exactly one cycle of delay.
            running <= 1'b1;
            state_q <= StRun;
            if (wrap) begin
               prescaler_q   <= '0;
               one_hz_enable <= 1'b1;
               if (last_tick) begin
                  expired_pulse <= 1'b1;
                  if (auto_reload) begin
                     remaining <= reload_q;
                  end else begin
                     remaining <= '0;
                     expired   <= 1'b1;
                     running   <= 1'b0;
                     state_q   <= StIdle;
                  end
               end else begin
                  remaining <= remaining - CntOne;
               end
            end else begin
               prescaler_q <= prescaler_q + PsWidth'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_prog_timer.sv
// Self-checking bench for prog_timer (PRESCALE = 10, CNT_W = 5) plus a second
// instance with PRESCALE = 1. The reference model tracks the absolute cycle of
// the next tick and pushes it out by one for every paused cycle.
module tb_prog_timer;

   localparam int P = 10;

   logic       clock;
   logic       reset;
   logic [4:0] value;
   logic       start_timer;
   logic       pause;
   logic       cancel;
   logic       auto_reload;
   logic       expired;
   logic       expired_pulse;
   logic       one_hz_enable;
   logic       running;
   logic [4:0] remaining;

   logic       p1_expired;
   logic       p1_expired_pulse;
   logic       p1_one_hz_enable;
   logic       p1_running;
   logic [4:0] p1_remaining;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model state.
   logic       m_active   = 1'b0;
   logic       m_paused   = 1'b0;
   logic [4:0] m_rem      = '0;
   logic [4:0] m_reload   = '0;
   int         m_deadline = 0;
   logic       e_exp      = 1'b0;
   logic       e_pulse    = 1'b0;
   logic       e_tick     = 1'b0;
   logic       e_run      = 1'b0;

   prog_timer #(
      .CLK_HZ (10),
      .TICK_HZ(1),
      .CNT_W  (5)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .value        (value),
      .start_timer  (start_timer),
      .pause        (pause),
      .cancel       (cancel),
      .auto_reload  (auto_reload),
      .expired      (expired),
      .expired_pulse(expired_pulse),
      .one_hz_enable(one_hz_enable),
      .running      (running),
      .remaining    (remaining)
   );

   prog_timer #(
      .CLK_HZ (4),
      .TICK_HZ(4),
      .CNT_W  (5)
   ) dut_p1 (
      .clock        (clock),
      .reset        (reset),
      .value        (value),
      .start_timer  (start_timer),
      .pause        (pause),
      .cancel       (cancel),
      .auto_reload  (auto_reload),
      .expired      (p1_expired),
      .expired_pulse(p1_expired_pulse),
      .one_hz_enable(p1_one_hz_enable),
      .running      (p1_running),
      .remaining    (p1_remaining)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: one step per rising edge, using the inputs seen at that edge.
   always @(posedge clock) begin
      cyc = cyc + 1;
      e_tick  = 1'b0;
      e_pulse = 1'b0;
      if (reset) begin
         m_active = 1'b0;
         m_paused = 1'b0;
         m_rem    = '0;
         m_reload = '0;
         e_exp    = 1'b0;
      end else if (start_timer) begin
         m_rem    = value;
         m_reload = value;
         m_paused = 1'b0;
         e_exp    = 1'b0;
         if (value == 5'd0) begin
            e_pulse  = 1'b1;
            e_exp    = 1'b1;
            m_active = 1'b0;
         end else begin
            m_active   = 1'b1;
            m_deadline = cyc + P;
         end
      end else if (m_active && cancel) begin
         m_active = 1'b0;
         m_paused = 1'b0;
         m_rem    = '0;
      end else if (m_active && pause) begin
         m_paused   = 1'b1;
         m_deadline = m_deadline + 1;
      end else if (m_active) begin
         m_paused = 1'b0;
         if (cyc == m_deadline) begin
            e_tick     = 1'b1;
            m_deadline = cyc + P;
            m_rem      = m_rem - 5'd1;
            if (m_rem == 5'd0) begin
               e_pulse = 1'b1;
               if (auto_reload) begin
                  m_rem = m_reload;
               end else begin
                  m_active = 1'b0;
                  e_exp    = 1'b1;
               end
            end
         end
      end
      e_run = m_active && !m_paused;
   end

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      checks++;
      if ({expired, expired_pulse, one_hz_enable, running, remaining} !== 9'd0) begin
         errors++;
         $display("FAIL reset_outputs got %b%b%b%b %0d want all zero",
                  expired, expired_pulse, one_hz_enable, running, remaining);
      end
      checks++;
      if ({p1_expired, p1_expired_pulse, p1_one_hz_enable, p1_running, p1_remaining} !== 9'd0) begin
         errors++;
         $display("FAIL reset_outputs_p1 got %b%b%b%b %0d want all zero", p1_expired,
                  p1_expired_pulse, p1_one_hz_enable, p1_running, p1_remaining);
      end
      reset = 1'b0;
   endtask

   task automatic test_prescale_one();
      int e, off;
      value = 5'd3;
      start_timer = 1'b1;
      @(negedge clock);
      start_timer = 1'b0;
      e = cyc;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         off = cyc - e;
         checks++;
         if (p1_one_hz_enable !== (off <= 3)) begin
            errors++;
            $display("FAIL p1_tick off=%0d got %b want %b", off, p1_one_hz_enable, off <= 3);
         end
         checks++;
         if (p1_expired_pulse !== (off == 3)) begin
            errors++;
            $display("FAIL p1_pulse off=%0d got %b want %b", off, p1_expired_pulse, off == 3);
         end
         checks++;
         if (p1_remaining !== 5'((off >= 3) ? 0 : 3 - off)) begin
            errors++;
            $display("FAIL p1_remaining off=%0d got %0d want %0d", off, p1_remaining,
                     (off >= 3) ? 0 : 3 - off);
         end
         checks++;
         if (p1_running !== (off < 3)) begin
            errors++;
            $display("FAIL p1_running off=%0d got %b want %b", off, p1_running, off < 3);
         end
      end
      checks++;
      if (p1_expired !== 1'b1) begin
         errors++;
         $display("FAIL p1_expired got %b want 1", p1_expired);
      end
   endtask

   task automatic test_one_shot();
      int e, off;
      value = 5'd3;
      auto_reload = 1'b0;
      start_timer = 1'b1;
      @(negedge clock);
      start_timer = 1'b0;
      e = cyc;
      checks++;
      if (running !== 1'b1 || remaining !== 5'd3 || expired !== 1'b0) begin
         errors++;
         $display("FAIL one_shot_load got run=%b rem=%0d exp=%b want 1 3 0",
                  running, remaining, expired);
      end
      for (int k = 0; k < 36; k++) begin
         @(negedge clock);
         off = cyc - e;
         checks++;
         if (one_hz_enable !== (off == 10 || off == 20 || off == 30)) begin
            errors++;
            $display("FAIL one_shot_tick off=%0d got %b", off, one_hz_enable);
         end
         checks++;
         if (expired_pulse !== (off == 30)) begin
            errors++;
            $display("FAIL one_shot_pulse off=%0d got %b want %b", off, expired_pulse, off == 30);
         end
         checks++;
         if (remaining !== 5'((off >= 30) ? 0 : 3 - off / 10)) begin
            errors++;
            $display("FAIL one_shot_remaining off=%0d got %0d want %0d", off, remaining,
                     (off >= 30) ? 0 : 3 - off / 10);
         end
         checks++;
         if ({expired, expired_pulse, one_hz_enable, running, remaining} !==
             {e_exp, e_pulse, e_tick, e_run, m_rem}) begin
            errors++;
            $display("FAIL one_shot_model cyc=%0d got %b%b%b%b %0d want %b%b%b%b %0d", cyc,
                     expired, expired_pulse, one_hz_enable, running, remaining,
                     e_exp, e_pulse, e_tick, e_run, m_rem);
         end
      end
      checks++;
      if (expired !== 1'b1 || running !== 1'b0) begin
         errors++;
         $display("FAIL one_shot_end got exp=%b run=%b want 1 0", expired, running);
      end
   endtask

   task automatic test_zero();
      value = 5'd0;
      start_timer = 1'b1;
      @(negedge clock);
      start_timer = 1'b0;
      checks++;
      if ({expired, expired_pulse, one_hz_enable, running, remaining} !== {4'b1100, 5'd0}) begin
         errors++;
         $display("FAIL zero_expiry got %b%b%b%b %0d want 1100 0",
                  expired, expired_pulse, one_hz_enable, running, remaining);
      end
      @(negedge clock);
      checks++;
      if (expired_pulse !== 1'b0 || expired !== 1'b1) begin
         errors++;
         $display("FAIL zero_after got pulse=%b exp=%b want 0 1", expired_pulse, expired);
      end
      for (int k = 0; k < 15; k++) begin
         @(negedge clock);
         checks++;
         if (one_hz_enable !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle got tick=%b run=%b want 0 0", one_hz_enable, running);
         end
      end
   endtask

   task automatic test_auto_reload();
      int e, off;
      value = 5'd2;
      auto_reload = 1'b1;
      start_timer = 1'b1;
      @(negedge clock);
      start_timer = 1'b0;
      e = cyc;
      for (int k = 0; k < 62; k++) begin
         @(negedge clock);
         off = cyc - e;
         checks++;
         if (expired_pulse !== (off % 20 == 0)) begin
            errors++;
            $display("FAIL reload_pulse off=%0d got %b want %b", off, expired_pulse, off % 20 == 0);
         end
         checks++;
         if (one_hz_enable !== (off % 10 == 0)) begin
            errors++;
            $display("FAIL reload_tick off=%0d got %b want %b", off, one_hz_enable, off % 10 == 0);
         end
         checks++;
         if (running !== 1'b1 || expired !== 1'b0) begin
            errors++;
            $display("FAIL reload_level off=%0d got run=%b exp=%b want 1 0", off, running, expired);
         end
         checks++;
         if (remaining !== ((off % 20 >= 10) ? 5'd1 : 5'd2)) begin
            errors++;
            $display("FAIL reload_remaining off=%0d got %0d want %0d", off, remaining,
                     (off % 20 >= 10) ? 1 : 2);
         end
      end
      auto_reload = 1'b0;
      cancel = 1'b1;
      @(negedge clock);
      cancel = 1'b0;
      checks++;
      if ({expired, expired_pulse, running, remaining} !== 8'd0) begin
         errors++;
         $display("FAIL reload_cancel got %b%b%b %0d want 000 0",
                  expired, expired_pulse, running, remaining);
      end
   endtask

   task automatic test_pause();
      int e, off;
      value = 5'd4;
      start_timer = 1'b1;
      @(negedge clock);
      start_timer = 1'b0;
      e = cyc;
      for (int k = 0; k < 52; k++) begin
         @(negedge clock);
         off = cyc - e;
         checks++;
         if (one_hz_enable !== (off == 10 || off == 27 || off == 37 || off == 47)) begin
            errors++;
            $display("FAIL pause_tick off=%0d got %b", off, one_hz_enable);
         end
         checks++;
         if (expired_pulse !== (off == 47)) begin
            errors++;
            $display("FAIL pause_pulse off=%0d got %b want %b", off, expired_pulse, off == 47);
         end
         checks++;
         if (running !== ((off < 47) && !(off >= 13 && off <= 19))) begin
            errors++;
            $display("FAIL pause_running off=%0d got %b", off, running);
         end
         checks++;
         if ({expired, expired_pulse, one_hz_enable, running, remaining} !==
             {e_exp, e_pulse, e_tick, e_run, m_rem}) begin
            errors++;
            $display("FAIL pause_model cyc=%0d got %b%b%b%b %0d want %b%b%b%b %0d", cyc,
                     expired, expired_pulse, one_hz_enable, running, remaining,
                     e_exp, e_pulse, e_tick, e_run, m_rem);
         end
         pause = (off >= 12 && off < 19);
      end
      checks++;
      if (expired !== 1'b1) begin
         errors++;
         $display("FAIL pause_end got exp=%b want 1", expired);
      end
   endtask

   task automatic test_restart_cancel();
      int e, off;
      value = 5'd5;
      start_timer = 1'b1;
      @(negedge clock);
      start_timer = 1'b0;
      e = cyc;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         off = cyc - e;
         checks++;
         if (expired_pulse !== 1'b0) begin
            errors++;
            $display("FAIL restart_early_pulse off=%0d got %b want 0", off, expired_pulse);
         end
      end
      checks++;
      if (remaining !== 5'd1) begin
         errors++;
         $display("FAIL restart_pre_remaining got %0d want 1", remaining);
      end
      value = 5'd4;
      start_timer = 1'b1;
      @(negedge clock);
      start_timer = 1'b0;
      e = cyc;
      checks++;
      if (remaining !== 5'd4 || running !== 1'b1 || expired_pulse !== 1'b0) begin
         errors++;
         $display("FAIL restart_load got rem=%0d run=%b pulse=%b want 4 1 0",
                  remaining, running, expired_pulse);
      end
      for (int k = 0; k < 42; k++) begin
         @(negedge clock);
         off = cyc - e;
         checks++;
         if (expired_pulse !== (off == 40)) begin
            errors++;
            $display("FAIL restart_pulse off=%0d got %b want %b", off, expired_pulse, off == 40);
         end
      end
      checks++;
      if (expired !== 1'b1 || running !== 1'b0) begin
         errors++;
         $display("FAIL restart_end got exp=%b run=%b want 1 0", expired, running);
      end
      // Cancel mid-run.
      value = 5'd5;
      start_timer = 1'b1;
      @(negedge clock);
      start_timer = 1'b0;
      repeat (15) @(negedge clock);
      cancel = 1'b1;
      @(negedge clock);
      cancel = 1'b0;
      checks++;
      if ({expired, expired_pulse, running, remaining} !== 8'd0) begin
         errors++;
         $display("FAIL cancel_state got %b%b%b %0d want 000 0",
                  expired, expired_pulse, running, remaining);
      end
      for (int k = 0; k < 60; k++) begin
         @(negedge clock);
         checks++;
         if (expired_pulse !== 1'b0 || one_hz_enable !== 1'b0 || expired !== 1'b0) begin
            errors++;
            $display("FAIL cancel_quiet got pulse=%b tick=%b exp=%b want 0 0 0",
                     expired_pulse, one_hz_enable, expired);
         end
      end
   endtask

   task automatic test_reset_midrun();
      value = 5'd7;
      start_timer = 1'b1;
      @(negedge clock);
      start_timer = 1'b0;
      repeat (25) @(negedge clock);
      reset = 1'b1;
      start_timer = 1'b1;
      value = 5'd9;
      @(negedge clock);
      reset = 1'b0;
      start_timer = 1'b0;
      checks++;
      if ({expired, expired_pulse, one_hz_enable, running, remaining} !== 9'd0) begin
         errors++;
         $display("FAIL reset_midrun got %b%b%b%b %0d want all zero",
                  expired, expired_pulse, one_hz_enable, running, remaining);
      end
      repeat (12) @(negedge clock);
      checks++;
      if (running !== 1'b0 || remaining !== 5'd0 || one_hz_enable !== 1'b0) begin
         errors++;
         $display("FAIL reset_midrun_idle got run=%b rem=%0d tick=%b want 0 0 0",
                  running, remaining, one_hz_enable);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 4000; k++) begin
         @(negedge clock);
         checks++;
         if ({expired, expired_pulse, one_hz_enable, running, remaining} !==
             {e_exp, e_pulse, e_tick, e_run, m_rem}) begin
            errors++;
            $display("FAIL random_model cyc=%0d got %b%b%b%b %0d want %b%b%b%b %0d", cyc,
                     expired, expired_pulse, one_hz_enable, running, remaining,
                     e_exp, e_pulse, e_tick, e_run, m_rem);
         end
         reset       = ($urandom_range(0, 599) == 0);
         start_timer = ($urandom_range(0, 59) == 0);
         value       = 5'($urandom_range(0, 6));
         cancel      = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 19) == 0) pause = ~pause;
         if ($urandom_range(0, 99) == 0) auto_reload = ~auto_reload;
      end
      reset = 1'b0;
      start_timer = 1'b0;
      cancel = 1'b0;
      pause = 1'b0;
      auto_reload = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      value       = '0;
      start_timer = 1'b0;
      pause       = 1'b0;
      cancel      = 1'b0;
      auto_reload = 1'b0;
      test_reset();
      test_prescale_one();
      test_one_shot();
      test_zero();
      test_auto_reload();
      test_pause();
      test_restart_cancel();
      test_reset_midrun();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
